// File: rtl/mealy_fsm_pkg.sv
// Shared types and built-in table contents for mealy_fsm_prog.
// The built-in table applies only to the 2-bit state / 1-bit input /
// 2-bit output configuration. Any other parameter set resets every entry
// to {RESET_STATE, 0}.
package mealy_fsm_pkg;

  localparam int unsigned DEF_STATE_W = 2;
  localparam int unsigned DEF_IN_W    = 1;
  localparam int unsigned DEF_OUT_W   = 2;
  localparam int unsigned DEF_ADDR_W  = DEF_STATE_W + DEF_IN_W;
  localparam int unsigned DEF_ENTRIES = 1 << DEF_ADDR_W;

  typedef struct packed {
    logic [DEF_STATE_W-1:0] next;
    logic [DEF_OUT_W-1:0]   out;
  } entry_2x1x2_t;

  // Indexed by {state, x}.
  localparam entry_2x1x2_t DEFAULT_TABLE_2x1x2 [DEF_ENTRIES] = '{
    '{next: 2'd0, out: 2'b01},   // (0,0)
    '{next: 2'd2, out: 2'b00},   // (0,1)
    '{next: 2'd0, out: 2'b00},   // (1,0)
    '{next: 2'd1, out: 2'b01},   // (1,1)
    '{next: 2'd1, out: 2'b10},   // (2,0)
    '{next: 2'd0, out: 2'b00},   // (2,1)
    '{next: 2'd3, out: 2'b10},   // (3,0)
    '{next: 2'd3, out: 2'b00}    // (3,1)
  };

  function automatic entry_2x1x2_t default_entry(input logic [DEF_ADDR_W-1:0] idx);
    return DEFAULT_TABLE_2x1x2[idx];
  endfunction

endpackage

// File: rtl/mealy_fsm_prog_if.sv
// Step and configuration bus of mealy_fsm_prog.
//   master: en, restart, x, cfg_we, cfg_addr, cfg_next, cfg_out -> ; <- y, state, timeout
//   slave : the machine side (mirror of master)
interface mealy_fsm_prog_if #(
  parameter int unsigned STATE_W = 2,
  parameter int unsigned IN_W    = 1,
  parameter int unsigned OUT_W   = 2
);
  logic                      en;
  logic                      restart;
  logic [IN_W-1:0]           x;
  logic [OUT_W-1:0]          y;
  logic [STATE_W-1:0]        state;
  logic                      cfg_we;
  logic [STATE_W+IN_W-1:0]   cfg_addr;
  logic [STATE_W-1:0]        cfg_next;
  logic [OUT_W-1:0]          cfg_out;
  logic                      timeout;

  modport master (
    output en, restart, x, cfg_we, cfg_addr, cfg_next, cfg_out,
    input  y, state, timeout
  );

  modport slave (
    input  en, restart, x, cfg_we, cfg_addr, cfg_next, cfg_out,
    output y, state, timeout
  );
endinterface

// File: rtl/fsm_dwell_mon.sv
// Dwell monitor: counts consecutive enabled steps that leave the state
// unchanged and raises a registered timeout when the count hits DWELL_MAX.
//   clk, reset  : clock, asynchronous active-high reset
//   en          : step enable of the machine
//   restart     : synchronous restart; clears counter and timeout
//   same_state  : the step taken this cycle would keep the current state
//   timeout     : dwell limit reached (held until state change/restart/reset)
module fsm_dwell_mon #(
  parameter int unsigned DWELL_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic restart,
  input  logic same_state,
  output logic timeout
);

  localparam int unsigned CNT_W = (DWELL_MAX > 0) ? $clog2(DWELL_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL_MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_d;

  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout;
    if (restart) begin
      cnt_d     = '0;
      timeout_d = 1'b0;
    end else if (en) begin
      if (same_state)
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      else
        cnt_d = '0;
      // Flag is derived from the post-step count so it rises on the
      // step that reaches the limit, not one step later.
      timeout_d = (DWELL_MAX != 0) && (cnt_d == CNT_MAX);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      timeout <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      timeout <= timeout_d;
    end
  end

endmodule

// File: rtl/mealy_fsm_prog.sv
// Table-driven, run-time programmable Mealy machine.
//   clk, reset : clock, asynchronous active-high reset (also reverts the table)
//   bus.en     : step enable        bus.restart : synchronous return to RESET_STATE
//   bus.x      : input symbol       bus.y       : output symbol
//   bus.state  : current state      bus.timeout : dwell limit reached
//   bus.cfg_*  : table write port, entry index {state, x}
module mealy_fsm_prog
  import mealy_fsm_pkg::*;
#(
  parameter int unsigned STATE_W     = 2,
  parameter int unsigned IN_W        = 1,
  parameter int unsigned OUT_W       = 2,
  parameter int unsigned RESET_STATE = 0,
  parameter int unsigned REG_OUT     = 0,
  parameter int unsigned DWELL_MAX   = 15
) (
  input logic              clk,
  input logic              reset,
  mealy_fsm_prog_if.slave  bus
);

  localparam int unsigned ADDR_W  = STATE_W + IN_W;
  localparam int unsigned ENTRIES = 1 << ADDR_W;
  localparam bit USE_BUILTIN = (STATE_W == DEF_STATE_W) && (IN_W == DEF_IN_W)
                               && (OUT_W == DEF_OUT_W);
  localparam logic [STATE_W-1:0] RESET_ST = STATE_W'(RESET_STATE);

  if (RESET_STATE >= (1 << STATE_W)) begin : g_bad_reset_state
    $error("mealy_fsm_prog: RESET_STATE %0d out of range for STATE_W %0d",
           RESET_STATE, STATE_W);
  end

  function automatic logic [STATE_W-1:0] reset_next(input int unsigned idx);
    entry_2x1x2_t e;
    e = default_entry(DEF_ADDR_W'(idx));
    if (USE_BUILTIN) return STATE_W'(e.next);
    return RESET_ST;
  endfunction

  function automatic logic [OUT_W-1:0] reset_out(input int unsigned idx);
    entry_2x1x2_t e;
    e = default_entry(DEF_ADDR_W'(idx));
    if (USE_BUILTIN) return OUT_W'(e.out);
    return '0;
  endfunction

  logic [STATE_W-1:0] tbl_next [ENTRIES];
  logic [OUT_W-1:0]   tbl_out  [ENTRIES];

  logic [STATE_W-1:0] state_q, state_d;
  logic [ADDR_W-1:0]  idx;
  logic [STATE_W-1:0] cur_next;
  logic [OUT_W-1:0]   cur_out;
  logic               same_state;

  assign idx = {state_q, bus.x};

  // Table: reads are combinational, so a write to the entry in use this
  // cycle only takes effect after the edge (read-before-write).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tbl_next[ADDR_W'(i)] <= reset_next(i);
        tbl_out[ADDR_W'(i)]  <= reset_out(i);
      end
    end else if (bus.cfg_we) begin
      tbl_next[bus.cfg_addr] <= bus.cfg_next;
      tbl_out[bus.cfg_addr]  <= bus.cfg_out;
    end
  end

  always_comb begin
    cur_next   = tbl_next[idx];
    cur_out    = tbl_out[idx];
    same_state = (cur_next == state_q);
    state_d    = state_q;
    if (bus.restart)
      state_d = RESET_ST;
    else if (bus.en)
      state_d = cur_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= RESET_ST;
    else
      state_q <= state_d;
  end

  assign bus.state = state_q;

  if (REG_OUT != 0) begin : g_reg_out
    logic [OUT_W-1:0] y_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        y_q <= '0;
      else if (bus.restart)
        y_q <= '0;
      else if (bus.en)
        y_q <= cur_out;
    end
    assign bus.y = y_q;
  end else begin : g_comb_out
    assign bus.y = cur_out;
  end

  fsm_dwell_mon #(
    .DWELL_MAX (DWELL_MAX)
  ) u_dwell (
    .clk        (clk),
    .reset      (reset),
    .en         (bus.en),
    .restart    (bus.restart),
    .same_state (same_state),
    .timeout    (bus.timeout)
  );

endmodule

// File: tb/tb_mealy_fsm_prog.sv
// Bench for mealy_fsm_prog: two instances (combinational output with
// DWELL_MAX=15, registered output with DWELL_MAX=3) share one stimulus.
// A table-level model is compared on every negative edge, and directed
// steps carry hand-computed literal expectations.
module tb_mealy_fsm_prog;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       en, restart, x, cfg_we;
  logic [2:0] cfg_addr;
  logic [1:0] cfg_next, cfg_out;

  mealy_fsm_prog_if #(.STATE_W(2), .IN_W(1), .OUT_W(2)) bus_a ();
  mealy_fsm_prog_if #(.STATE_W(2), .IN_W(1), .OUT_W(2)) bus_b ();

  assign bus_a.en = en;             assign bus_b.en = en;
  assign bus_a.restart = restart;   assign bus_b.restart = restart;
  assign bus_a.x = x;               assign bus_b.x = x;
  assign bus_a.cfg_we = cfg_we;     assign bus_b.cfg_we = cfg_we;
  assign bus_a.cfg_addr = cfg_addr; assign bus_b.cfg_addr = cfg_addr;
  assign bus_a.cfg_next = cfg_next; assign bus_b.cfg_next = cfg_next;
  assign bus_a.cfg_out = cfg_out;   assign bus_b.cfg_out = cfg_out;

  mealy_fsm_prog #(
    .STATE_W(2), .IN_W(1), .OUT_W(2), .RESET_STATE(0), .REG_OUT(0), .DWELL_MAX(15)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );

  mealy_fsm_prog #(
    .STATE_W(2), .IN_W(1), .OUT_W(2), .RESET_STATE(0), .REG_OUT(1), .DWELL_MAX(3)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  bit run_cmp = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  int m_next [8];
  int m_out  [8];
  int m_state, m_yreg;
  int m_cnt [2];
  bit m_to  [2];
  int dmax  [2] = '{15, 3};

  task automatic model_reset();
    m_next  = '{0, 2, 0, 1, 1, 0, 3, 3};
    m_out   = '{1, 0, 0, 1, 2, 0, 2, 0};
    m_state = 0;
    m_yreg  = 0;
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      m_to[k]  = 1'b0;
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_reset();
    end else begin
      int e_idx, nxt, o;
      e_idx = m_state * 2 + int'(x);
      nxt = m_next[e_idx];
      o   = m_out[e_idx];
      if (restart) begin
        m_state = 0;
        m_yreg  = 0;
        for (int k = 0; k < 2; k++) begin
          m_cnt[k] = 0;
          m_to[k]  = 1'b0;
        end
      end else if (en) begin
        for (int k = 0; k < 2; k++) begin
          if (nxt == m_state) m_cnt[k] = (m_cnt[k] + 1 > dmax[k]) ? dmax[k] : m_cnt[k] + 1;
          else m_cnt[k] = 0;
          m_to[k] = (dmax[k] != 0) && (m_cnt[k] == dmax[k]);
        end
        m_yreg  = o;
        m_state = nxt;
      end
      if (cfg_we) begin
        m_next[int'(cfg_addr)] = int'(cfg_next);
        m_out[int'(cfg_addr)]  = int'(cfg_out);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (run_cmp && !reset) begin
      chk("cyc_state_a", int'(bus_a.state), m_state);
      chk("cyc_state_b", int'(bus_b.state), m_state);
      chk("cyc_y_comb", int'(bus_a.y), m_out[m_state * 2 + int'(x)]);
      chk("cyc_y_reg", int'(bus_b.y), m_yreg);
      chk("cyc_timeout_a", int'(bus_a.timeout), int'(m_to[0]));
      chk("cyc_timeout_b", int'(bus_b.timeout), int'(m_to[1]));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input bit e, input bit r, input bit xx, input bit we,
                       input int a, input int n, input int o);
    @(posedge clk);
    #1;
    en = e; restart = r; x = xx; cfg_we = we;
    cfg_addr = 3'(a); cfg_next = 2'(n); cfg_out = 2'(o);
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b0; restart = 1'b0; x = 1'b0; cfg_we = 1'b0;
    cfg_addr = '0; cfg_next = '0; cfg_out = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    run_cmp = 1'b1;
    @(negedge clk);
    chk("rst_state", int'(bus_a.state), 0);
    chk("rst_y_reg", int'(bus_b.y), 0);
    chk("rst_timeout", int'(bus_b.timeout), 0);
    chk("rst_y_comb", int'(bus_a.y), 1);

    // x = 1,0,0,1 from state 0: path 0->2->1->0->2, y 00,10,00,00
    drive(1, 0, 1, 0, 0, 0, 0); @(negedge clk);
    chk("p1_y", int'(bus_a.y), 0);
    drive(1, 0, 0, 0, 0, 0, 0); @(negedge clk);
    chk("p2_state", int'(bus_a.state), 2);
    chk("p2_y", int'(bus_a.y), 2);
    chk("p2_yreg", int'(bus_b.y), 0);
    drive(1, 0, 0, 0, 0, 0, 0); @(negedge clk);
    chk("p3_state", int'(bus_a.state), 1);
    chk("p3_yreg", int'(bus_b.y), 2);
    drive(1, 0, 1, 0, 0, 0, 0); @(negedge clk);
    chk("p4_state", int'(bus_a.state), 0);
    drive(0, 0, 1, 0, 0, 0, 0); @(negedge clk);
    chk("p5_state", int'(bus_a.state), 2);
    drive(0, 0, 0, 0, 0, 0, 0); @(negedge clk);
    chk("hold_state", int'(bus_a.state), 2);

    // program (2,0) -> 3/01 while disabled
    drive(0, 0, 0, 1, 4, 3, 1); @(negedge clk);
    chk("wr_not_yet", int'(bus_a.y), 2);
    drive(1, 0, 0, 0, 0, 0, 0); @(negedge clk);
    chk("wr_visible", int'(bus_a.y), 1);
    drive(0, 0, 0, 0, 0, 0, 0); @(negedge clk);
    chk("in_s3", int'(bus_a.state), 3);
    chk("freeze_yreg", int'(bus_b.y), 1);
    drive(1, 0, 0, 0, 0, 0, 0); @(negedge clk);
    chk("freeze_yreg2", int'(bus_b.y), 1);
    drive(1, 0, 0, 0, 0, 0, 0); @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0); @(negedge clk);
    chk("dwell_pre", int'(bus_b.timeout), 0);
    drive(1, 0, 0, 0, 0, 0, 0); @(negedge clk);
    chk("dwell_rise", int'(bus_b.timeout), 1);
    chk("dwell_a_low", int'(bus_a.timeout), 0);
    drive(1, 1, 0, 0, 0, 0, 0); @(negedge clk);
    chk("dwell_hold", int'(bus_b.timeout), 1);
    drive(1, 0, 1, 0, 0, 0, 0); @(negedge clk);
    chk("restart_to", int'(bus_b.timeout), 0);
    chk("restart_state", int'(bus_a.state), 0);
    drive(1, 0, 0, 0, 0, 0, 0); @(negedge clk);
    chk("back_s2", int'(bus_a.state), 2);

    // program (3,1) -> 0/11, then same-cycle write of (3,0) -> 1/00
    drive(0, 0, 0, 1, 7, 0, 3); @(negedge clk);
    chk("s3_again", int'(bus_a.state), 3);
    drive(1, 0, 0, 1, 6, 1, 0); @(negedge clk);
    chk("rbw_old_y", int'(bus_a.y), 2);
    drive(0, 0, 0, 0, 0, 0, 0); @(negedge clk);
    chk("rbw_old_next", int'(bus_a.state), 3);
    chk("rbw_new_y", int'(bus_a.y), 0);
    drive(1, 0, 1, 0, 0, 0, 0); @(negedge clk);
    chk("prog_y11", int'(bus_a.y), 3);
    drive(1, 0, 1, 0, 0, 0, 0); @(negedge clk);
    chk("prog_next0", int'(bus_a.state), 0);
    chk("prog_yreg11", int'(bus_b.y), 3);

    // restart with en=0, then restart beating en=1
    drive(0, 1, 0, 0, 0, 0, 0); @(negedge clk);
    chk("pre_rst_s2", int'(bus_a.state), 2);
    drive(1, 0, 1, 0, 0, 0, 0); @(negedge clk);
    chk("restart_en0", int'(bus_a.state), 0);
    drive(1, 1, 0, 0, 0, 0, 0); @(negedge clk);
    chk("pre_rst2_s2", int'(bus_a.state), 2);
    drive(0, 0, 1, 1, 1, 2, 3); @(negedge clk);
    chk("restart_wins", int'(bus_a.state), 0);
    chk("restart_yreg", int'(bus_b.y), 0);
    drive(1, 0, 1, 0, 0, 0, 0); @(negedge clk);
    chk("prog01_y", int'(bus_a.y), 3);
    drive(0, 0, 1, 0, 0, 0, 0); @(negedge clk);
    chk("pre_ar_state", int'(bus_a.state), 2);
    chk("pre_ar_yreg", int'(bus_b.y), 3);

    // asynchronous reset mid-period, no clock edge involved
    #2 reset = 1'b1;
    #1;
    chk("ar_state", int'(bus_a.state), 0);
    chk("ar_yreg", int'(bus_b.y), 0);
    chk("ar_timeout", int'(bus_b.timeout), 0);
    chk("ar_tbl_y01", int'(bus_a.y), 0);
    @(posedge clk);
    #1;
    reset = 1'b0; en = 1'b1; restart = 1'b0; x = 1'b1; cfg_we = 1'b0;
    @(negedge clk);
    chk("ar_post_state", int'(bus_a.state), 0);
    drive(0, 0, 0, 0, 0, 0, 0); @(negedge clk);
    chk("ar_next2", int'(bus_a.state), 2);
    chk("ar_out00", int'(bus_b.y), 0);
    chk("ar_tbl_y20", int'(bus_a.y), 2);

    run_cmp = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
